// File: rtl/bridge_pkg.sv
// bridge_pkg: shared constants, FSM encodings and helpers for cpu_axi_bridge.
//   INST_ID_DEF / DATA_ID_DEF  default AXI IDs for instruction / data accesses
//   AXI_LEN_SINGLE / AXI_BURST_INCR  fixed single-beat INCR burst attributes
//   rd_state_t / wr_state_t    read and write FSM encodings
//   gen_wstrb()                byte-lane strobe from sram-like size + addr[1:0]
package bridge_pkg;

  localparam logic [3:0] INST_ID_DEF    = 4'd0;
  localparam logic [3:0] DATA_ID_DEF    = 4'd1;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } wr_state_t;

  // size 3 has no legal byte-lane pattern on a 32-bit bus, so no lanes are enabled.
  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      2'd2:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/axi_rd_ctrl.sv
// axi_rd_ctrl: read FSM and inst/data arbitration for the shared AR/R channels.
//   inst_* / data_*      sram-like request side (data has priority over inst)
//   hazard               data read must wait (pending write to the same word)
//   inst_addrok/data_addrok  combinational accept pulses
//   ar* / r*             AXI read address / data channel signals
//   r_inst_fire/r_data_fire  R handshake this cycle, split by rid
//
// state  | meaning
// R_IDLE | no read outstanding; arbitrate and accept a request
// R_AR   | arvalid asserted with the latched address, waiting for arready
// R_R    | rready asserted, waiting for the single R beat
module axi_rd_ctrl
  import bridge_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              hazard,
  output logic              inst_addrok,
  output logic              data_addrok,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic              rvalid,
  output logic              rready,
  output logic              r_inst_fire,
  output logic              r_data_fire
);

  rd_state_t         state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [3:0]        id_q;
  logic              take_data, take_inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= R_IDLE;
      addr_q <= '0;
      size_q <= '0;
      id_q   <= '0;
    end else begin
      state <= state_nx;
      if (take_data) begin
        addr_q <= data_addr;
        size_q <= data_size;
        id_q   <= DATA_ID;
      end else if (take_inst) begin
        addr_q <= inst_addr;
        size_q <= inst_size;
        id_q   <= INST_ID;
      end
    end
  end

  // rready stays high in R_R: on an R/B collision the read wins and the
  // write side holds off bready instead.
  always_comb begin
    state_nx  = state;
    take_data = 1'b0;
    take_inst = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state)
      R_IDLE: begin
        if (data_req && !data_wr && !hazard) begin
          take_data = 1'b1;
          state_nx  = R_AR;
        end else if (inst_req) begin
          take_inst = 1'b1;
          state_nx  = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) state_nx = R_R;
      end
      R_R: begin
        rready = 1'b1;
        if (rvalid) state_nx = R_IDLE;
      end
      default: state_nx = R_IDLE;
    endcase
  end

  assign inst_addrok = take_inst;
  assign data_addrok = take_data;
  assign arid        = id_q;
  assign araddr      = addr_q;
  assign arsize      = {1'b0, size_q};
  assign r_inst_fire = rvalid && rready && (rid == INST_ID);
  assign r_data_fire = rvalid && rready && (rid == DATA_ID);

endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: converts the CPU inst/data sram-like ports into one AXI master
// with one outstanding read (either port) and one outstanding write (data port).
//   clk, reset                 clock, async active-high reset
//   inst_sram_*                instruction port (read only)
//   data_sram_*                data port (reads and writes)
//   ar*/r*, aw*/w*, b*         AXI master channels, single-beat INCR bursts
// Build option: define BRIDGE_RESP_REG_EN to register rdata and both dataok
// outputs (one extra cycle of response latency); default is combinational.
//
// state  | meaning
// W_IDLE | no write outstanding; accept a data write
// W_AW   | awvalid / wvalid driven until each has handshaken
// W_B    | waiting for the write response
module cpu_axi_bridge
  import bridge_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 32,
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  output logic              inst_sram_addrok,
  output logic              inst_sram_dataok,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              data_sram_addrok,
  output logic              data_sram_dataok,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [3:0]        wid,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  wr_state_t         w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        w_size_q;
  logic              aw_done, w_done;
  logic              w_take, b_fire, hazard;
  logic              rd_data_addrok, r_inst_fire, r_data_fire;
  logic              unused_inputs;

  // Only single-beat OKAY-agnostic traffic is issued, so these carry no information.
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wdata, rresp, rlast, bid, bresp};

  // A data read to the word a pending write targets must not overtake it.
  assign hazard = (w_state != W_IDLE) &&
                  (data_sram_addr[ADDR_W-1:2] == w_addr_q[ADDR_W-1:2]);

  axi_rd_ctrl #(
    .ADDR_W  (ADDR_W),
    .INST_ID (INST_ID),
    .DATA_ID (DATA_ID)
  ) u_rd (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_sram_req),
    .inst_size   (inst_sram_size),
    .inst_addr   (inst_sram_addr),
    .data_req    (data_sram_req),
    .data_wr     (data_sram_wr),
    .data_size   (data_sram_size),
    .data_addr   (data_sram_addr),
    .hazard      (hazard),
    .inst_addrok (inst_sram_addrok),
    .data_addrok (rd_data_addrok),
    .arid        (arid),
    .araddr      (araddr),
    .arsize      (arsize),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rvalid      (rvalid),
    .rready      (rready),
    .r_inst_fire (r_inst_fire),
    .r_data_fire (r_data_fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state  <= W_IDLE;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      w_size_q <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (w_take) begin
        w_addr_q <= data_sram_addr;
        w_data_q <= data_sram_wdata;
        w_strb_q <= gen_wstrb(data_sram_size, data_sram_addr[1:0]);
        w_size_q <= data_sram_size;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  // bready is withheld in a cycle where a data-ID R beat completes so that
  // data_sram_dataok carries at most one event per cycle.
  always_comb begin
    w_state_nx = w_state;
    w_take     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (data_sram_req && data_sram_wr) begin
          w_take     = 1'b1;
          w_state_nx = W_AW;
        end
      end
      W_AW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) w_state_nx = W_B;
      end
      W_B: begin
        bready = !r_data_fire;
        if (bvalid && !r_data_fire) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  assign b_fire           = bvalid && bready;
  assign data_sram_addrok = rd_data_addrok || w_take;

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = DATA_ID;
  assign awaddr  = w_addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = {1'b0, w_size_q};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid   = DATA_ID;
  assign wdata = w_data_q;
  assign wstrb = w_strb_q;
  assign wlast = 1'b1;

`ifdef BRIDGE_RESP_REG_EN
  logic [DATA_W-1:0] rdata_q;
  logic              inst_dataok_q, data_dataok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q       <= '0;
      inst_dataok_q <= 1'b0;
      data_dataok_q <= 1'b0;
    end else begin
      inst_dataok_q <= r_inst_fire;
      data_dataok_q <= r_data_fire || b_fire;
      if (r_inst_fire || r_data_fire) rdata_q <= rdata;
    end
  end

  assign inst_sram_rdata  = rdata_q;
  assign data_sram_rdata  = rdata_q;
  assign inst_sram_dataok = inst_dataok_q;
  assign data_sram_dataok = data_dataok_q;
`else
  assign inst_sram_rdata  = rdata;
  assign data_sram_rdata  = rdata;
  assign inst_sram_dataok = r_inst_fire;
  assign data_sram_dataok = r_data_fire || b_fire;
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        inst_sram_addrok, inst_sram_dataok;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        data_sram_addrok, data_sram_dataok;
  logic [3:0]  arid, rid, awid, wid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .inst_sram_addrok(inst_sram_addrok), .inst_sram_dataok(inst_sram_dataok),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .data_sram_addrok(data_sram_addrok), .data_sram_dataok(data_sram_dataok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  logic done = 1'b0;

  logic [31:0] inst_q[$];
  logic [31:0] dread_q[$];
  logic [31:0] dwrite_q[$];
  logic [31:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Scoreboard side: every dataok pulse consumes one expected response.
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_sram_dataok) begin
        if (inst_q.size() == 0) chk("inst_unexpected_dataok", inst_sram_dataok, 1'b0);
        else begin
          mon_e = inst_q.pop_front();
          chk("inst_rdata", inst_sram_rdata, mon_e);
        end
      end
      if (data_sram_dataok) begin
        if (rvalid && rready && rid == 4'd1) begin
          if (dread_q.size() == 0) chk("data_unexpected_rd", data_sram_dataok, 1'b0);
          else begin
            mon_e = dread_q.pop_front();
            chk("data_rdata", data_sram_rdata, mon_e);
          end
        end else if (bvalid && bready) begin
          if (dwrite_q.size() == 0) chk("data_unexpected_wr", data_sram_dataok, 1'b0);
          else begin
            mon_e = dwrite_q.pop_front();
            chk("data_wr_done_addr", awaddr, mon_e);
          end
        end else chk("data_dataok_no_source", data_sram_dataok, 1'b0);
      end
    end
  end

  // Caller has just had its read accepted and dropped req; runs AR then one R beat.
  task automatic serve_read(input logic [3:0] id, input logic [31:0] d);
    arready = 1'b1;
    at_neg();
    chk("sr_arvalid", arvalid, 1'b1);
    chk("sr_arid", arid, id);
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = id; rdata = d;
    at_neg();
    step();
    rvalid = 1'b0;
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    data_sram_req = 1'b1; data_sram_wr = 1'b1;
    data_sram_addr = a; data_sram_size = sz; data_sram_wdata = d;
    at_neg();
    chk("wr_addrok", data_sram_addrok, 1'b1);
    dwrite_q.push_back(a);
    step();
    data_sram_req = 1'b0; data_sram_wr = 1'b0;
  endtask

  task automatic complete_aw_w(input logic [3:0] exp_strb, input logic [31:0] exp_data);
    awready = 1'b1; wready = 1'b1;
    at_neg();
    chk("aw_valid", awvalid, 1'b1);
    chk("w_valid", wvalid, 1'b1);
    chk("w_strb", wstrb, exp_strb);
    chk("w_data", wdata, exp_data);
    step();
    awready = 1'b0; wready = 1'b0;
  endtask

  initial begin
    #50000;
    chk("watchdog_done", done, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_dataok", {inst_sram_dataok, data_sram_dataok}, 2'b00);
    chk("rst_araddr", araddr, 32'h0);
    chk("const_arlen_burst", {arlen, arburst, awlen, awburst}, {8'd0, 2'b01, 8'd0, 2'b01});
    chk("const_wlast", wlast, 1'b1);
    step();
    reset = 1'b0;
    step();

    // Minimum-latency instruction read.
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000; inst_sram_size = 2'd2;
    at_neg();
    chk("t1_inst_addrok", inst_sram_addrok, 1'b1);
    chk("t1_data_addrok", data_sram_addrok, 1'b0);
    inst_q.push_back(32'h3C08_0001);
    step();
    inst_sram_req = 1'b0; arready = 1'b1;
    at_neg();
    chk("t1_arvalid", arvalid, 1'b1);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    chk("t1_arid", arid, 4'd0);
    chk("t1_arsize", arsize, 3'd2);
    step();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C08_0001;
    at_neg();
    chk("t1_rready", rready, 1'b1);
    chk("t1_dataok_t2", inst_sram_dataok, 1'b1);
    step();
    rvalid = 1'b0;
    at_neg();
    chk("t1_dataok_single", inst_sram_dataok, 1'b0);
    chk("t1_arvalid_idle", arvalid, 1'b0);
    step();

    // Simultaneous inst and data reads: data wins.
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1000_0010; data_sram_size = 2'd2;
    at_neg();
    chk("t2_data_addrok", data_sram_addrok, 1'b1);
    chk("t2_inst_addrok", inst_sram_addrok, 1'b0);
    dread_q.push_back(32'h1111_2222);
    step();
    data_sram_req = 1'b0; arready = 1'b1;
    at_neg();
    chk("t2_arid", arid, 4'd1);
    chk("t2_araddr", araddr, 32'h1000_0010);
    chk("t2_inst_wait_ar", inst_sram_addrok, 1'b0);
    step();
    arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_2222;
    at_neg();
    chk("t2_inst_wait_r", inst_sram_addrok, 1'b0);
    step();
    rvalid = 1'b0;
    at_neg();
    chk("t2_inst_addrok_after", inst_sram_addrok, 1'b1);
    inst_q.push_back(32'hAABB_CCDD);
    step();
    inst_sram_req = 1'b0;
    serve_read(4'd0, 32'hAABB_CCDD);

    // Byte write, W handshakes first, AW delayed three cycles.
    issue_write(32'h8000_0003, 2'd0, 32'h0000_00AB);
    awready = 1'b0; wready = 1'b1;
    at_neg();
    chk("t3_awvalid", awvalid, 1'b1);
    chk("t3_wvalid", wvalid, 1'b1);
    chk("t3_wstrb", wstrb, 4'b1000);
    chk("t3_wdata", wdata, 32'h0000_00AB);
    chk("t3_awaddr", awaddr, 32'h8000_0003);
    chk("t3_awsize_ids", {awsize, awid, wid}, {3'd0, 4'd1, 4'd1});
    step();
    wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t3_wvalid_dropped", wvalid, 1'b0);
      chk("t3_awvalid_hold", awvalid, 1'b1);
      chk("t3_no_early_dataok", data_sram_dataok, 1'b0);
      step();
    end
    awready = 1'b1;
    at_neg();
    chk("t3_awvalid_last", awvalid, 1'b1);
    step();
    awready = 1'b0;
    at_neg();
    chk("t3_bready", bready, 1'b1);
    chk("t3_awvalid_done", awvalid, 1'b0);
    chk("t3_dataok_wait_b", data_sram_dataok, 1'b0);
    step();
    bvalid = 1'b1;
    at_neg();
    chk("t3_dataok_on_b", data_sram_dataok, 1'b1);
    step();
    bvalid = 1'b0;
    at_neg();
    chk("t3_dataok_single", data_sram_dataok, 1'b0);
    step();

    // Read-after-write hazard on the same word; a different word proceeds.
    issue_write(32'h0000_0100, 2'd2, 32'hDEAD_BEEF);
    complete_aw_w(4'b1111, 32'hDEAD_BEEF);
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0102; data_sram_size = 2'd1;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("t4_hazard_block", data_sram_addrok, 1'b0);
      step();
    end
    data_sram_addr = 32'h0000_0200; data_sram_size = 2'd2;
    at_neg();
    chk("t4_other_word_ok", data_sram_addrok, 1'b1);
    dread_q.push_back(32'h2002_0020);
    step();
    data_sram_req = 1'b0;
    serve_read(4'd1, 32'h2002_0020);
    data_sram_req = 1'b1; data_sram_addr = 32'h0000_0102; data_sram_size = 2'd1;
    at_neg();
    chk("t4_hazard_still", data_sram_addrok, 1'b0);
    step();
    bvalid = 1'b1;
    at_neg();
    chk("t4_hazard_during_b", data_sram_addrok, 1'b0);
    chk("t4_bready", bready, 1'b1);
    step();
    bvalid = 1'b0;
    at_neg();
    chk("t4_hazard_clear", data_sram_addrok, 1'b1);
    dread_q.push_back(32'h1021_0210);
    step();
    data_sram_req = 1'b0;
    serve_read(4'd1, 32'h1021_0210);

    // R/B collision: read dataok first, write dataok next cycle.
    issue_write(32'h0000_0302, 2'd1, 32'h0000_BEEF);
    complete_aw_w(4'b1100, 32'h0000_BEEF);
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h0000_0400; data_sram_size = 2'd2;
    at_neg();
    chk("t5_rd_addrok", data_sram_addrok, 1'b1);
    dread_q.push_back(32'h4004_0040);
    step();
    data_sram_req = 1'b0; arready = 1'b1;
    at_neg();
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h4004_0040; bvalid = 1'b1;
    at_neg();
    chk("t5_bready_blocked", bready, 1'b0);
    chk("t5_rready", rready, 1'b1);
    chk("t5_rd_dataok", data_sram_dataok, 1'b1);
    step();
    rvalid = 1'b0;
    at_neg();
    chk("t5_bready_next", bready, 1'b1);
    chk("t5_wr_dataok", data_sram_dataok, 1'b1);
    step();
    bvalid = 1'b0;
    at_neg();
    chk("t5_dataok_quiet", data_sram_dataok, 1'b0);
    step();

    // Reset while arvalid is up, then a fresh read.
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0010;
    at_neg();
    chk("t6_addrok", inst_sram_addrok, 1'b1);
    step();
    inst_sram_req = 1'b0; arready = 1'b0;
    at_neg();
    chk("t6_arvalid_pre", arvalid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_arvalid_async", arvalid, 1'b0);
    chk("t6_araddr_cleared", araddr, 32'h0);
    step();
    step();
    reset = 1'b0;
    at_neg();
    chk("t6_arvalid_after", arvalid, 1'b0);
    step();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    at_neg();
    chk("t6_new_addrok", inst_sram_addrok, 1'b1);
    inst_q.push_back(32'h2402_0007);
    step();
    inst_sram_req = 1'b0;
    serve_read(4'd0, 32'h2402_0007);
    at_neg();

    chk("sb_inst_empty", inst_q.size(), 0);
    chk("sb_dread_empty", dread_q.size(), 0);
    chk("sb_dwrite_empty", dwrite_q.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
